// File: rtl/sme_pkg.sv
// Shared constants, sizes and FSM state type for the string-matching engine.
package sme_pkg;

   localparam int unsigned CHAR_W  = 8;
   localparam int unsigned STR_MAX = 32;
   localparam int unsigned PAT_MAX = 8;
   localparam int unsigned IDX_W   = $clog2(STR_MAX);
   localparam int unsigned LEN_W   = $clog2(STR_MAX + 1);
   localparam int unsigned PIDX_W  = $clog2(PAT_MAX);
   localparam int unsigned PLEN_W  = $clog2(PAT_MAX + 1);

   localparam logic [CHAR_W-1:0] HAT    = CHAR_W'(8'h5E);
   localparam logic [CHAR_W-1:0] DOLLAR = CHAR_W'(8'h24);
   localparam logic [CHAR_W-1:0] POINT  = CHAR_W'(8'h2E);
   localparam logic [CHAR_W-1:0] STAR   = CHAR_W'(8'h2A);
   localparam logic [CHAR_W-1:0] SPACE  = CHAR_W'(8'h20);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SCAN = 2'd2,
      S_DONE = 2'd3
   } sme_state_e;

endpackage

// File: rtl/sme_if.sv
// Character-stream and result bus between the front end (master) and the engine (slave).
interface sme_if;
   import sme_pkg::*;

   logic [CHAR_W-1:0] chardata;
   logic              isstring;
   logic              ispattern;
   logic              ready;
   logic              valid;
   logic              match;
   logic [IDX_W-1:0]  match_index;
   logic              ovf;

   modport master (output chardata, isstring, ispattern,
                   input  ready, valid, match, match_index, ovf);
   modport slave  (input  chardata, isstring, ispattern,
                   output ready, valid, match, match_index, ovf);
endinterface

// File: rtl/sme_tok_cmp.sv
// Combinational evaluation of one pattern token against the string at position pos_i.
// SME_CASE_FOLD_EN: literal compares ignore ASCII letter case.
module sme_tok_cmp
   import sme_pkg::*;
(
   input  logic [CHAR_W-1:0] s_ch_i,
   input  logic [CHAR_W-1:0] p_ch_i,
   input  logic [LEN_W-1:0]  pos_i,
   input  logic [LEN_W-1:0]  frame_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              ok_c_o,
   output logic              consume_c_o,
   output logic              is_star_c_o
);

   logic [CHAR_W-1:0] s_cmp;
   logic [CHAR_W-1:0] p_cmp;
   logic              at_end;
   logic              s_space;
   logic              lit_eq;

`ifdef SME_CASE_FOLD_EN
   function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
      if ((c >= CHAR_W'(8'h41)) && (c <= CHAR_W'(8'h5A))) return c | CHAR_W'(8'h20);
      return c;
   endfunction
   assign s_cmp = fold(s_ch_i);
   assign p_cmp = fold(p_ch_i);
`else
   assign s_cmp = s_ch_i;
   assign p_cmp = p_ch_i;
`endif

   // Metacharacters decode on the raw pattern char; anything else is a literal.
   always_comb begin
      ok_c_o      = 1'b0;
      consume_c_o = 1'b0;
      at_end      = (pos_i >= len_i);
      s_space     = !at_end && (s_ch_i == SPACE);
      lit_eq      = !at_end && (s_cmp == p_cmp);
      is_star_c_o = (p_ch_i == STAR);
      case (p_ch_i)
         HAT: begin
            if (pos_i == '0) begin
               ok_c_o = 1'b1;
            end else if (s_space && (pos_i == frame_i)) begin
               ok_c_o      = 1'b1;
               consume_c_o = 1'b1;
            end
         end
         DOLLAR: begin
            if (at_end) begin
               ok_c_o = 1'b1;
            end else if (s_space) begin
               ok_c_o      = 1'b1;
               consume_c_o = 1'b1;
            end
         end
         POINT: begin
            ok_c_o      = !at_end;
            consume_c_o = !at_end;
         end
         default: begin
            ok_c_o      = lit_eq;
            consume_c_o = lit_eq;
         end
      endcase
   end

endmodule

// File: rtl/sme_param_engine.sv
// String-matching engine: loads a string and pattern, then scans for the leftmost match.
// Build option SME_CASE_FOLD_EN enables case-insensitive literals (see sme_tok_cmp).
module sme_param_engine
   import sme_pkg::*;
(
   input logic  clk,
   input logic  reset,
   sme_if.slave bus
);

   sme_state_e        state_q, state_d;
   logic [CHAR_W-1:0] str_q [STR_MAX];
   logic [CHAR_W-1:0] pat_q [PAT_MAX];
   logic [LEN_W-1:0]  slen_q, slen_d, k_q, k_d, i_q, i_d, si_q, si_d, start_q, start_d;
   logic [PLEN_W-1:0] plen_q, plen_d, j_q, j_d, sj_q, sj_d;
   logic [PIDX_W-1:0] spos_q, spos_d, pat_wa;
   logic [IDX_W-1:0]  index_q, index_d, str_wa;
   logic              seen_q, seen_d, spos_v_q, spos_v_d, star_v_q, star_v_d;
   logic              ready_q, ready_d, valid_q, valid_d, match_q, match_d, ovf_q, ovf_d;
   logic              accept, job_start, str_we, pat_we;
   logic              tok_ok, tok_consume, tok_star;
   logic [CHAR_W-1:0] s_ch, p_ch;

   assign s_ch = str_q[IDX_W'(i_q)];
   assign p_ch = pat_q[PIDX_W'(j_q)];

   sme_tok_cmp u_tok (
      .s_ch_i      (s_ch),
      .p_ch_i      (p_ch),
      .pos_i       (i_q),
      .frame_i     (k_q),
      .len_i       (slen_q),
      .ok_c_o      (tok_ok),
      .consume_c_o (tok_consume),
      .is_star_c_o (tok_star)
   );

   always_comb begin
      state_d  = state_q;
      slen_d   = slen_q;
      plen_d   = plen_q;
      seen_d   = seen_q;
      spos_d   = spos_q;
      spos_v_d = spos_v_q;
      k_d      = k_q;
      i_d      = i_q;
      j_d      = j_q;
      si_d     = si_q;
      sj_d     = sj_q;
      star_v_d = star_v_q;
      start_d  = start_q;
      match_d  = match_q;
      index_d  = index_q;
      ovf_d    = ovf_q;
      str_we   = 1'b0;
      pat_we   = 1'b0;
      str_wa   = '0;
      pat_wa   = '0;
      accept    = ready_q && (bus.isstring || bus.ispattern);
      job_start = accept && (state_q != S_LOAD);

      // A new job wipes the pattern; the string is only wiped by the job's first string char.
      if (job_start) begin
         plen_d   = '0;
         seen_d   = 1'b0;
         spos_v_d = 1'b0;
         ovf_d    = 1'b0;
      end
      if (accept) begin
         if (bus.isstring) begin
            if (!seen_d) begin
               str_we = 1'b1;
               slen_d = LEN_W'(1);
               seen_d = 1'b1;
            end else if (slen_q < LEN_W'(STR_MAX)) begin
               str_we = 1'b1;
               str_wa = IDX_W'(slen_q);
               slen_d = slen_q + LEN_W'(1);
            end else begin
               ovf_d = 1'b1;
            end
         end else if (plen_d < PLEN_W'(PAT_MAX)) begin
            pat_we = 1'b1;
            pat_wa = PIDX_W'(plen_d);
            if ((bus.chardata == STAR) && !spos_v_d) begin
               spos_v_d = 1'b1;
               spos_d   = PIDX_W'(plen_d);
            end
            plen_d = plen_d + PLEN_W'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end

      case (state_q)
         S_IDLE, S_DONE: state_d = accept ? S_LOAD : S_IDLE;
         S_LOAD: begin
            if (!accept) begin
               state_d  = S_SCAN;
               k_d      = '0;
               i_d      = '0;
               j_d      = '0;
               si_d     = '0;
               sj_d     = '0;
               star_v_d = 1'b0;
               start_d  = '0;
            end
         end
         S_SCAN: begin
            if (j_q == plen_q) begin
               state_d = S_DONE;
               match_d = 1'b1;
               index_d = IDX_W'(start_q);
            end else if (tok_star && spos_v_q && (PIDX_W'(j_q) == spos_q)) begin
               si_d     = i_q;
               sj_d     = j_q + PLEN_W'(1);
               star_v_d = 1'b1;
               j_d      = j_q + PLEN_W'(1);
            end else if (tok_ok) begin
               i_d = i_q + LEN_W'(tok_consume);
               j_d = j_q + PLEN_W'(1);
               if ((p_ch == HAT) && tok_consume) start_d = i_q + LEN_W'(1);
            end else if (star_v_q && (si_q < slen_q)) begin
               // Let the star swallow one more char and retry the tail.
               si_d = si_q + LEN_W'(1);
               i_d  = si_q + LEN_W'(1);
               j_d  = sj_q;
            end else if (k_q == slen_q) begin
               state_d = S_DONE;
               match_d = 1'b0;
            end else begin
               k_d      = k_q + LEN_W'(1);
               i_d      = k_q + LEN_W'(1);
               j_d      = '0;
               star_v_d = 1'b0;
               start_d  = k_q + LEN_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d != S_SCAN);
      valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         slen_q   <= '0;
         plen_q   <= '0;
         seen_q   <= 1'b0;
         spos_q   <= '0;
         spos_v_q <= 1'b0;
         k_q      <= '0;
         i_q      <= '0;
         j_q      <= '0;
         si_q     <= '0;
         sj_q     <= '0;
         star_v_q <= 1'b0;
         start_q  <= '0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         match_q  <= 1'b0;
         index_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         slen_q   <= slen_d;
         plen_q   <= plen_d;
         seen_q   <= seen_d;
         spos_q   <= spos_d;
         spos_v_q <= spos_v_d;
         k_q      <= k_d;
         i_q      <= i_d;
         j_q      <= j_d;
         si_q     <= si_d;
         sj_q     <= sj_d;
         star_v_q <= star_v_d;
         start_q  <= start_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
         match_q  <= match_d;
         index_q  <= index_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned x = 0; x < STR_MAX; x++) str_q[x] <= '0;
         for (int unsigned x = 0; x < PAT_MAX; x++) pat_q[x] <= '0;
      end else begin
         if (str_we) str_q[str_wa] <= bus.chardata;
         if (pat_we) pat_q[pat_wa] <= bus.chardata;
      end
   end

   assign bus.ready       = ready_q;
   assign bus.valid       = valid_q;
   assign bus.match       = match_q;
   assign bus.match_index = index_q;
   assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_sme_param_engine.sv
// Scoreboard bench for sme_param_engine: expected results queued per job, checked on valid.
module tb_sme_param_engine;
   import sme_pkg::*;

`ifdef SME_CASE_FOLD_EN
   localparam bit FOLD = 1'b1;
`else
   localparam bit FOLD = 1'b0;
`endif

   typedef struct packed {
      logic             match;
      logic [IDX_W-1:0] idx;
      logic             ovf;
   } exp_t;

   logic  clk = 1'b0;
   logic  reset;
   sme_if bus ();
   exp_t  exp_q[$];
   int    checks = 0;
   int    failures = 0;
   int    valid_cnt = 0;

   sme_param_engine dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Result monitor: every valid pops one expectation.
   always @(negedge clk) begin
      exp_t e;
      if (bus.valid === 1'b1) begin
         valid_cnt++;
         if (exp_q.size() == 0) begin
            check_eq("spurious_valid", 32'(bus.valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("match", 32'(bus.match), 32'(e.match));
            if (e.match) check_eq("match_index", 32'(bus.match_index), 32'(e.idx));
            check_eq("ovf", 32'(bus.ovf), 32'(e.ovf));
         end
      end
   end

   task automatic drive_idle();
      bus.chardata  = 8'h00;
      bus.isstring  = 1'b0;
      bus.ispattern = 1'b0;
   endtask

   task automatic drive_char(input logic [7:0] c, input bit is_s, input bit is_p);
      bus.chardata  = c;
      bus.isstring  = is_s;
      bus.ispattern = is_p;
      @(negedge clk);
   endtask

   task automatic load_job(input string s, input string p, input bit last_both);
      for (int x = 0; x < s.len(); x++)
         drive_char(s[x], 1'b1, last_both && (x == s.len() - 1));
      for (int x = 0; x < p.len(); x++)
         drive_char(p[x], 1'b0, 1'b1);
      drive_idle();
   endtask

   task automatic run_job(input string s, input string p, input bit last_both,
                          input int n, input int m, input bit e_match, input int e_idx,
                          input bit e_ovf, input int garbage, output int lat);
      exp_t e;
      int   bound;
      bit   seen;
      e.match = e_match;
      e.idx   = IDX_W'(e_idx);
      e.ovf   = e_ovf;
      exp_q.push_back(e);
      load_job(s, p, last_both);
      bound = (n + 1) * (n + m + 1) + 2;
      lat   = 0;
      seen  = 1'b0;
      while (!seen && (lat < bound + 8)) begin
         @(negedge clk);
         lat++;
         if (bus.valid === 1'b1) begin
            seen = 1'b1;
         end else begin
            if ((lat == 1) && (garbage > 0)) check_eq("ready_low_in_scan", 32'(bus.ready), 32'd0);
            if (lat <= garbage) begin
               bus.chardata  = 8'h78;
               bus.isstring  = lat[0];
               bus.ispattern = 1'b1;
            end else begin
               drive_idle();
            end
         end
      end
      drive_idle();
      check_eq("valid_seen", 32'(seen), 32'd1);
      check_eq("latency_bound", 32'(lat <= bound), 32'd1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int    lat;
      int    snap;
      string long_s;

      reset = 1'b1;
      drive_idle();
      @(negedge clk);
      check_eq("rst_ready", 32'(bus.ready), 32'd1);
      check_eq("rst_valid", 32'(bus.valid), 32'd0);
      check_eq("rst_match", 32'(bus.match), 32'd0);
      check_eq("rst_index", 32'(bus.match_index), 32'd0);
      check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_job("hello world", "wor", 1'b0, 11, 3, 1'b1, 6, 1'b0, 3, lat);
      run_job("", "^wor", 1'b0, 11, 4, 1'b1, 6, 1'b0, 0, lat);
      run_job("", "^orl", 1'b0, 11, 4, 1'b0, 0, 1'b0, 0, lat);
      run_job("abcde", "c.e$", 1'b0, 5, 4, 1'b1, 2, 1'b0, 0, lat);
      run_job("", "b.d$", 1'b0, 5, 4, 1'b0, 0, 1'b0, 0, lat);
      run_job("foo bar baz", "o*z", 1'b0, 11, 3, 1'b1, 1, 1'b0, 2, lat);

      // Abort a running scan with reset; no result may appear afterwards.
      load_job("hello world", "xyz", 1'b0);
      repeat (3) @(negedge clk);
      check_eq("scan_busy_ready", 32'(bus.ready), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check_eq("abort_valid", 32'(bus.valid), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check_eq("ready_after_release", 32'(bus.ready), 32'd1);
      snap = valid_cnt;
      repeat (60) @(negedge clk);
      check_eq("no_valid_after_abort", 32'(valid_cnt - snap), 32'd0);

      long_s = "";
      for (int x = 0; x < 40; x++) long_s = $sformatf("%s%c", long_s, 8'(8'h61 + (x % 26)));
      run_job(long_s, "f$", 1'b0, 32, 2, 1'b1, 31, 1'b1, 0, lat);
      run_job("ab", "", 1'b0, 2, 0, 1'b1, 0, 1'b0, 0, lat);
      check_eq("empty_pat_latency", 32'(lat), 32'd2);
      run_job("ab", "**", 1'b0, 2, 2, 1'b0, 0, 1'b0, 0, lat);
      run_job("abc", "c$", 1'b1, 3, 2, 1'b1, 2, 1'b0, 0, lat);
      run_job("abc", "$", 1'b0, 3, 1, 1'b1, 3, 1'b0, 0, lat);
      run_job("ab", "b.", 1'b0, 2, 2, 1'b0, 0, 1'b0, 0, lat);
      run_job("xabcdefgh", "abcdefghi", 1'b0, 9, 8, 1'b1, 1, 1'b1, 0, lat);
      run_job("Hello", "hel", 1'b0, 5, 3, FOLD, 0, 1'b0, 0, lat);

      repeat (4) @(negedge clk);
      check_eq("pending_expect", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
